dmem_responder: RTL and testbench

Word-addressed data-memory responder for the single-cycle RV32I core. It serves the core's `dmem_*` initiator port with a same-cycle combinational read path and a clocked write path. A small memory-mapped I/O window provides a console TX FIFO with a valid/ready drain port, a free-running cycle counter, and a halt/tohost register. Bench and top-level tie it directly to the core; it holds no instruction memory.

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_responder
//  Purpose  : Data-memory responder with RAM, console TX FIFO, cycle counter
//             and halt register. Optional bounds check: DMEM_BOUNDS_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic        dmem_write,
    input  logic        dmem_read,
    output logic [31:0] dmem_rdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halted,
    output logic [31:0] halt_code,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int          c_aw        = $clog2(DEPTH_WORDS);
    localparam int          c_pw        = $clog2(FIFO_DEPTH);
    localparam logic [c_pw:0] c_fifo_full = (c_pw+1)'(FIFO_DEPTH);

    logic [31:0]     r_mem [DEPTH_WORDS];
    logic [7:0]      r_fifo [FIFO_DEPTH];
    logic [c_pw-1:0] r_wptr;
    logic [c_pw-1:0] r_rptr;
    logic [c_pw:0]   r_count;
    logic            r_ovf;
    logic [31:0]     r_cycle;
    logic            r_halted;
    logic [31:0]     r_halt_code;

    logic            w_is_mmio;
    logic [1:0]      w_off;
    logic [c_aw-1:0] w_idx;
    logic            w_bad;
    logic            w_wr_en;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic            w_push_ok;

    assign w_is_mmio = (dmem_addr[31:4] == MMIO_BASE[31:4]);
    assign w_off     = dmem_addr[3:2];
    assign w_idx     = dmem_addr[c_aw+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [32:0] c_ram_bytes = 33'(DEPTH_WORDS) * 33'd4;

    logic        r_fault;
    logic [31:0] r_fault_addr;

    assign w_bad = (dmem_read || dmem_write) &&
                   ((dmem_addr[1:0] != 2'b00) ||
                    (!w_is_mmio && ({1'b0, dmem_addr} >= c_ram_bytes)));

    // Only the first offending address is latched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_fault      <= 1'b0;
            r_fault_addr <= 32'h0;
        end else if (w_bad && !r_fault) begin
            r_fault      <= 1'b1;
            r_fault_addr <= dmem_addr;
        end
    end

    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;
`else
    logic w_unused_ok;
    assign w_unused_ok = ^dmem_addr[1:0];
    assign w_bad       = 1'b0;
    assign fault       = 1'b0;
    assign fault_addr  = 32'h0;
`endif

    assign w_wr_en   = dmem_write && !r_halted && !w_bad;
    assign w_full    = (r_count == c_fifo_full);
    assign w_empty   = (r_count == '0);
    assign tx_valid  = !w_empty;
    assign tx_data   = tx_valid ? r_fifo[r_rptr] : 8'h00;
    assign w_pop     = tx_valid && tx_ready;
    assign w_push    = w_wr_en && w_is_mmio && (w_off == 2'd0);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_ok = w_push && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (w_wr_en && !w_is_mmio) begin
            r_mem[w_idx] <= dmem_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_fifo[r_wptr] <= dmem_wdata[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + (c_pw+1)'(w_push_ok) - (c_pw+1)'(w_pop);
            if (w_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle     <= 32'h0;
            r_halted    <= 1'b0;
            r_halt_code <= 32'h0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_en && w_is_mmio && (w_off == 2'd3)) begin
                r_halted    <= 1'b1;
                r_halt_code <= dmem_wdata;
            end
        end
    end

    assign halted    = r_halted;
    assign halt_code = r_halt_code;

    // Read path sees pre-write state, so a same-cycle store is not bypassed.
    always_comb begin
        dmem_rdata = 32'h0;
        if (dmem_read && !w_bad) begin
            if (w_is_mmio) begin
                case (w_off)
                    2'd1:    dmem_rdata = {29'b0, r_ovf, w_full, w_empty};
                    2'd2:    dmem_rdata = r_cycle;
                    2'd3:    dmem_rdata = r_halt_code;
                    default: dmem_rdata = 32'h0;
                endcase
            end else begin
                dmem_rdata = r_mem[w_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_responder
//  Purpose  : Self-checking bench for dmem_responder (vector table + sequences).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_responder;

    localparam int          DEPTH_WORDS = 1024;
    localparam int          FIFO_DEPTH  = 8;
    localparam logic [31:0] MMIO_BASE   = 32'hFFFF_0000;

    logic        clock;
    logic        reset;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_write;
    logic        dmem_read;
    logic [31:0] dmem_rdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halted;
    logic [31:0] halt_code;
    logic        fault;
    logic [31:0] fault_addr;

    dmem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .MMIO_BASE   (MMIO_BASE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_write (dmem_write),
        .dmem_read  (dmem_read),
        .dmem_rdata (dmem_rdata),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .halted     (halted),
        .halt_code  (halt_code),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          wr;
        bit          rd;
        bit          chk;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [12];
    logic [31:0] exp_q [$];
    logic [7:0]  tx_q [$];
    bit          m_ovf;
    logic [31:0] m_cycle;
    int          n_vec = 0;
    int          n_err = 0;

    always @(posedge clock or posedge reset) begin
        if (reset) m_cycle <= 32'h0;
        else       m_cycle <= m_cycle + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d);
        dmem_write = wr;
        dmem_read  = rd;
        dmem_addr  = a;
        dmem_wdata = d;
    endtask

    task automatic step;
        @(posedge clock);
        #1;
        drive(0, 0, 32'h0, 32'h0);
    endtask

    task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        drive(0, 1, a, 32'h0);
        exp_q.push_back(exp);
        @(negedge clock);
        check(name, dmem_rdata, exp_q.pop_front());
        step();
    endtask

    task automatic push_byte(input logic [7:0] b);
        drive(1, 0, MMIO_BASE, {24'h0, b});
        if (tx_q.size() < FIFO_DEPTH) tx_q.push_back(b);
        else                          m_ovf = 1'b1;
        step();
    endtask

    function automatic logic [31:0] exp_status();
        return {29'b0, m_ovf, tx_q.size() == FIFO_DEPTH, tx_q.size() == 0};
    endfunction

    task automatic drain(input string name, input int n);
        logic [7:0] b;
        tx_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check({name, "_valid"}, {31'b0, tx_valid}, 32'd1);
            b = tx_q.pop_front();
            check({name, "_data"}, {24'h0, tx_data}, {24'h0, b});
            step();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{0, 1, 1, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF};
        vecs[2]  = '{0, 0, 1, 32'h0000_0010, 32'h0,         32'h0};
        vecs[3]  = '{1, 0, 0, 32'h0000_0014, 32'h1234_5678, 32'h0};
        vecs[4]  = '{1, 1, 1, 32'h0000_0014, 32'hAAAA_5555, 32'h1234_5678};
        vecs[5]  = '{0, 1, 1, 32'h0000_0014, 32'h0,         32'hAAAA_5555};
        vecs[6]  = '{1, 0, 0, 32'h0000_0000, 32'h1111_1111, 32'h0};
        vecs[7]  = '{0, 1, 1, 32'h0000_0000, 32'h0,         32'h1111_1111};
        vecs[8]  = '{0, 1, 1, MMIO_BASE,     32'h0,         32'h0};
        vecs[9]  = '{1, 0, 0, MMIO_BASE + 4, 32'hFF,        32'h0};
        vecs[10] = '{1, 0, 0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0};
        vecs[11] = '{0, 1, 1, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D};

        reset    = 1'b1;
        tx_ready = 1'b0;
        m_ovf    = 1'b0;
        drive(0, 0, 32'h0, 32'h0);

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_rdata", dmem_rdata, 32'h0);
        check("rst_tx_valid", {31'b0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'h0, tx_data}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        check("rst_halt_code", halt_code, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'h0);
        check("rst_fault_addr", fault_addr, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // CYCLE five cycles after release
        repeat (5) step();
        read_check("cycle_5", MMIO_BASE + 8, 32'd5);
        read_check("status_reset", MMIO_BASE + 4, 32'b001);

        // RAM / MMIO vector table
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
            if (vecs[i].chk) exp_q.push_back(vecs[i].exp);
            @(negedge clock);
            if (vecs[i].chk) check($sformatf("vec%0d", i), dmem_rdata, exp_q.pop_front());
            step();
        end
        read_check("status_ro_write", MMIO_BASE + 4, 32'b001);

        // FIFO fill with overflow, then drain
        for (int i = 0; i < 9; i++) push_byte(8'h41 + 8'(i));
        read_check("status_full_ovf", MMIO_BASE + 4, exp_status());
        check("status_model_full", exp_status(), 32'b110);
        drain("fill_drain", 8);
        @(negedge clock);
        check("empty_tx_data", {24'h0, tx_data}, 32'h0);
        step();
        read_check("status_drained", MMIO_BASE + 4, 32'b101);

        // Async reset mid-run with pending bytes
        push_byte(8'h10);
        push_byte(8'h11);
        #2 reset = 1'b1;
        tx_q.delete();
        m_ovf = 1'b0;
        #1;
        check("rst1_tx_valid", {31'b0, tx_valid}, 32'h0);
        drive(0, 1, MMIO_BASE + 4, 32'h0);
        #1 check("rst1_status", dmem_rdata, 32'b001);
        drive(0, 1, MMIO_BASE + 8, 32'h0);
        #1 check("rst1_cycle", dmem_rdata, 32'h0);
        drive(0, 0, 32'h0, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) push_byte(8'h61 + 8'(i));
        tx_ready = 1'b1;
        drive(1, 0, MMIO_BASE, 32'h5A);
        @(negedge clock);
        check("pp_head", {24'h0, tx_data}, {24'h0, tx_q.pop_front()});
        tx_q.push_back(8'h5A);
        step();
        tx_ready = 1'b0;
        read_check("pp_status", MMIO_BASE + 4, 32'b010);
        drain("pp_drain", 8);
        read_check("pp_status_end", MMIO_BASE + 4, 32'b001);

        // Halt
        drive(1, 0, MMIO_BASE + 12, 32'h1);
        step();
        @(negedge clock);
        check("halted", {31'b0, halted}, 32'd1);
        check("halt_code", halt_code, 32'd1);
        step();
        read_check("halt_read", MMIO_BASE + 12, 32'd1);
        drive(1, 0, 32'h0, 32'h55);
        step();
        read_check("halt_ram_kept", 32'h0, 32'h1111_1111);
        read_check("halt_cycle_a", MMIO_BASE + 8, m_cycle);
        read_check("halt_cycle_b", MMIO_BASE + 8, m_cycle);
        drive(1, 0, MMIO_BASE + 12, 32'h99);
        step();
        check("halt_code_kept", halt_code, 32'd1);
        drive(1, 0, MMIO_BASE, 32'h33);
        step();
        check("halt_no_push", {31'b0, tx_valid}, 32'h0);

        // Reset clears halt, RAM survives
        #2 reset = 1'b1;
        #1;
        check("rst2_halted", {31'b0, halted}, 32'h0);
        check("rst2_halt_code", halt_code, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        read_check("rst2_ram_kept", 32'h0, 32'h1111_1111);

`ifdef DMEM_BOUNDS_CHECK_EN
        drive(1, 0, 32'h0000_1002, 32'h77);
        step();
        @(negedge clock);
        check("bc_fault", {31'b0, fault}, 32'd1);
        check("bc_fault_addr", fault_addr, 32'h0000_1002);
        step();
        read_check("bc_ram_kept", 32'h0, 32'h1111_1111);
        read_check("bc_oob_read", 32'h0000_1000, 32'h0);
        check("bc_first_only", fault_addr, 32'h0000_1002);
`else
        drive(1, 0, 32'(DEPTH_WORDS * 4 + 4), 32'hAA);
        step();
        read_check("alias_read", 32'h4, 32'hAA);
        check("no_fault", {31'b0, fault}, 32'h0);
        check("no_fault_addr", fault_addr, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
